// File: rtl/armleocpu_trap_sequencer.sv
// Trap/return sequencer between execute and the CSR unit: arbitrates exceptions,
// MRET/SRET and synchronized interrupts, issues the one-cycle CSR command, then holds a fetch redirect.
module armleocpu_trap_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          VECTORED    = 1'b0,
    localparam int unsigned ARMLEOCPU_CSR_CMD_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               irq_timer,
    input  logic                               irq_exti,
    input  logic                               irq_swi,
    input  logic                               irq_timer_en,
    input  logic                               irq_exti_en,
    input  logic                               irq_swi_en,

    input  logic [1:0]                         csr_mcurrent_privilege,
    input  logic                               csr_mstatus_tsr,
    input  logic [31:0]                        csr_mtvec,
    input  logic [31:0]                        csr_mepc,
    input  logic [31:0]                        csr_sepc,

    input  logic                               exc_valid,
    input  logic [31:0]                        exc_cause,
    input  logic                               mret_req,
    input  logic                               sret_req,
    input  logic [31:0]                        req_pc,
    input  logic                               int_allowed,

    output logic                               trap_ack,
    output logic                               busy,
    output logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] csr_cmd,
    output logic [31:0]                        csr_exc_cause,
    output logic [31:0]                        csr_exc_epc,

    output logic                               redirect_valid,
    output logic [31:0]                        redirect_pc,
    input  logic                               redirect_ready
);

    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_NONE            = ARMLEOCPU_CSR_CMD_WIDTH'(0);
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_MRET            = ARMLEOCPU_CSR_CMD_WIDTH'(1);
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_SRET            = ARMLEOCPU_CSR_CMD_WIDTH'(2);
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_INTERRUPT_BEGIN = ARMLEOCPU_CSR_CMD_WIDTH'(3);
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_EXCEPTION_BEGIN = ARMLEOCPU_CSR_CMD_WIDTH'(4);

    localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;
    localparam logic [3:0]  CODE_SWI            = 4'd3;
    localparam logic [3:0]  CODE_TIMER          = 4'd7;
    localparam logic [3:0]  CODE_EXTI           = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_REDIR
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_INT,
        KIND_MRET,
        KIND_SRET
    } kind_t;

    state_t                             r_state;
    kind_t                              r_kind;
    logic [3:0]                         r_code;
    logic                               r_busy;
    logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] r_csr_cmd;
    logic [31:0]                        r_exc_cause;
    logic [31:0]                        r_exc_epc;
    logic                               r_redirect_valid;
    logic [31:0]                        r_redirect_pc;

    logic [SYNC_STAGES-1:0] r_sync_timer;
    logic [SYNC_STAGES-1:0] r_sync_exti;
    logic [SYNC_STAGES-1:0] r_sync_swi;

    logic                               w_p_timer;
    logic                               w_p_exti;
    logic                               w_p_swi;
    logic                               w_sel_valid;
    kind_t                              w_sel_kind;
    logic [3:0]                         w_sel_code;
    logic [31:0]                        w_sel_cause;
    logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] w_sel_cmd;
    logic [31:0]                        w_mtvec_base;
    logic [31:0]                        w_target;

    // Raw irq lines are asynchronous; shift each through its own flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_timer <= '0;
            r_sync_exti  <= '0;
            r_sync_swi   <= '0;
        end else begin
            r_sync_timer <= {r_sync_timer[SYNC_STAGES-2:0], irq_timer};
            r_sync_exti  <= {r_sync_exti[SYNC_STAGES-2:0], irq_exti};
            r_sync_swi   <= {r_sync_swi[SYNC_STAGES-2:0], irq_swi};
        end
    end

    assign w_p_timer = r_sync_timer[SYNC_STAGES-1] & irq_timer_en;
    assign w_p_exti  = r_sync_exti[SYNC_STAGES-1] & irq_exti_en;
    assign w_p_swi   = r_sync_swi[SYNC_STAGES-1] & irq_swi_en;

    // Event arbitration; illegal returns are folded into an illegal-instruction exception.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_kind  = KIND_EXC;
        w_sel_code  = 4'd0;
        w_sel_cause = 32'd0;
        if (exc_valid) begin
            w_sel_valid = 1'b1;
            w_sel_cause = exc_cause;
        end else if (mret_req) begin
            w_sel_valid = 1'b1;
            if (csr_mcurrent_privilege == 2'b11) begin
                w_sel_kind = KIND_MRET;
            end else begin
                w_sel_cause = CAUSE_ILLEGAL_INSTR;
            end
        end else if (sret_req) begin
            w_sel_valid = 1'b1;
            if ((csr_mcurrent_privilege == 2'b00) ||
                ((csr_mcurrent_privilege == 2'b01) && csr_mstatus_tsr)) begin
                w_sel_cause = CAUSE_ILLEGAL_INSTR;
            end else begin
                w_sel_kind = KIND_SRET;
            end
        end else if (int_allowed && (w_p_exti || w_p_swi || w_p_timer)) begin
            w_sel_valid = 1'b1;
            w_sel_kind  = KIND_INT;
            if (w_p_exti) begin
                w_sel_code = CODE_EXTI;
            end else if (w_p_swi) begin
                w_sel_code = CODE_SWI;
            end else begin
                w_sel_code = CODE_TIMER;
            end
            w_sel_cause = {1'b1, 27'd0, w_sel_code};
        end
    end

    always_comb begin
        w_sel_cmd = CMD_EXCEPTION_BEGIN;
        case (w_sel_kind)
            KIND_INT:  w_sel_cmd = CMD_INTERRUPT_BEGIN;
            KIND_MRET: w_sel_cmd = CMD_MRET;
            KIND_SRET: w_sel_cmd = CMD_SRET;
            default:   w_sel_cmd = CMD_EXCEPTION_BEGIN;
        endcase
    end

    // Redirect target uses the CSR values present in the CMD cycle.
    assign w_mtvec_base = csr_mtvec & ~32'h3;

    always_comb begin
        w_target = w_mtvec_base;
        case (r_kind)
            KIND_INT:  w_target = w_mtvec_base + (VECTORED ? 32'({r_code, 2'b00}) : 32'd0);
            KIND_MRET: w_target = csr_mepc;
            KIND_SRET: w_target = csr_sepc;
            default:   w_target = w_mtvec_base;
        endcase
    end

    assign trap_ack = !rst && (r_state == S_IDLE) && w_sel_valid;

    // Sequencer: IDLE -> CMD (one cycle) -> REDIR (until fetch accepts).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_kind           <= KIND_EXC;
            r_code           <= 4'd0;
            r_busy           <= 1'b0;
            r_csr_cmd        <= CMD_NONE;
            r_exc_cause      <= 32'd0;
            r_exc_epc        <= 32'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_state     <= S_CMD;
                        r_busy      <= 1'b1;
                        r_kind      <= w_sel_kind;
                        r_code      <= w_sel_code;
                        r_csr_cmd   <= w_sel_cmd;
                        r_exc_cause <= w_sel_cause;
                        r_exc_epc   <= req_pc;
                    end
                end
                S_CMD: begin
                    r_state          <= S_REDIR;
                    r_csr_cmd        <= CMD_NONE;
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= w_target;
                end
                S_REDIR: begin
                    if (redirect_ready) begin
                        r_state          <= S_IDLE;
                        r_busy           <= 1'b0;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_busy           <= 1'b0;
                    r_csr_cmd        <= CMD_NONE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign csr_cmd        = r_csr_cmd;
    assign csr_exc_cause  = r_exc_cause;
    assign csr_exc_epc    = r_exc_epc;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_armleocpu_trap_sequencer.sv
// Bench for armleocpu_trap_sequencer: event-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_armleocpu_trap_sequencer;

    localparam int unsigned SYNC = 3;
    localparam bit          VEC  = 1'b1;
    localparam int          MAXC = 8192;
    localparam logic [3:0]  C_NONE = 4'd0;
    localparam logic [3:0]  C_MRET = 4'd1;
    localparam logic [3:0]  C_SRET = 4'd2;
    localparam logic [3:0]  C_INT  = 4'd3;
    localparam logic [3:0]  C_EXC  = 4'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_timer, irq_exti, irq_swi;
    logic        irq_timer_en, irq_exti_en, irq_swi_en;
    logic [1:0]  csr_mcurrent_privilege;
    logic        csr_mstatus_tsr;
    logic [31:0] csr_mtvec, csr_mepc, csr_sepc;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic        mret_req, sret_req;
    logic [31:0] req_pc;
    logic        int_allowed;
    logic        trap_ack, busy;
    logic [3:0]  csr_cmd;
    logic [31:0] csr_exc_cause, csr_exc_epc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    always #5 clk = ~clk;

    armleocpu_trap_sequencer #(
        .SYNC_STAGES(SYNC),
        .VECTORED   (VEC)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .irq_timer             (irq_timer),
        .irq_exti              (irq_exti),
        .irq_swi               (irq_swi),
        .irq_timer_en          (irq_timer_en),
        .irq_exti_en           (irq_exti_en),
        .irq_swi_en            (irq_swi_en),
        .csr_mcurrent_privilege(csr_mcurrent_privilege),
        .csr_mstatus_tsr       (csr_mstatus_tsr),
        .csr_mtvec             (csr_mtvec),
        .csr_mepc              (csr_mepc),
        .csr_sepc              (csr_sepc),
        .exc_valid             (exc_valid),
        .exc_cause             (exc_cause),
        .mret_req              (mret_req),
        .sret_req              (sret_req),
        .req_pc                (req_pc),
        .int_allowed           (int_allowed),
        .trap_ack              (trap_ack),
        .busy                  (busy),
        .csr_cmd               (csr_cmd),
        .csr_exc_cause         (csr_exc_cause),
        .csr_exc_epc           (csr_exc_epc),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .redirect_ready        (redirect_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit raw_t [MAXC];
    bit raw_e [MAXC];
    bit raw_s [MAXC];
    bit rst_h [MAXC];

    // Reference model: whether a sequence is in flight, its age in cycles, and last issued values.
    bit          m_active;
    int          m_age;
    int          m_kind;
    logic [3:0]  m_code;
    logic [3:0]  m_cmd;
    logic [31:0] m_cause, m_epc, m_rpc;

    logic        s_ack, s_busy, s_rv;
    logic [3:0]  s_cmd;
    logic [31:0] s_cause, s_epc, s_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // An irq line seen in cycle n is the raw level SYNC cycles earlier, unless reset intervened.
    function automatic bit synced(input int which, input int n);
        if (n < int'(SYNC)) return 1'b0;
        for (int m = n - int'(SYNC); m < n; m++) if (rst_h[m]) return 1'b0;
        case (which)
            0:       return raw_t[n - int'(SYNC)];
            1:       return raw_e[n - int'(SYNC)];
            default: return raw_s[n - int'(SYNC)];
        endcase
    endfunction

    task automatic step();
        bit          pt, pe, ps, sel_v;
        int          sel_kind;
        logic [3:0]  sel_code;
        logic [31:0] sel_cause;
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d want below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        s_ack = trap_ack; s_busy = busy; s_rv = redirect_valid;
        s_cmd = csr_cmd; s_cause = csr_exc_cause; s_epc = csr_exc_epc; s_rpc = redirect_pc;
        raw_t[cyc] = irq_timer; raw_e[cyc] = irq_exti; raw_s[cyc] = irq_swi; rst_h[cyc] = rst;

        pt = synced(0, cyc) & irq_timer_en;
        pe = synced(1, cyc) & irq_exti_en;
        ps = synced(2, cyc) & irq_swi_en;
        sel_v = 1'b1; sel_kind = 0; sel_code = 4'd0; sel_cause = 32'd0;
        if (exc_valid) sel_cause = exc_cause;
        else if (mret_req) begin
            if (csr_mcurrent_privilege == 2'b11) sel_kind = 2; else sel_cause = 32'd2;
        end else if (sret_req) begin
            if (csr_mcurrent_privilege == 2'b00 || (csr_mcurrent_privilege == 2'b01 && csr_mstatus_tsr))
                sel_cause = 32'd2;
            else sel_kind = 3;
        end else if (int_allowed && (pt || pe || ps)) begin
            sel_kind = 1;
            sel_code = pe ? 4'd11 : (ps ? 4'd3 : 4'd7);
            sel_cause = 32'h8000_0000 + 32'(sel_code);
        end else sel_v = 1'b0;

        chk("trap_ack", 32'(s_ack), 32'(!rst && !m_active && sel_v));
        chk("busy", 32'(s_busy), 32'(m_active));
        chk("csr_cmd", 32'(s_cmd), 32'((m_active && m_age == 1) ? m_cmd : C_NONE));
        chk("csr_exc_cause", s_cause, m_cause);
        chk("csr_exc_epc", s_epc, m_epc);
        chk("redirect_valid", 32'(s_rv), 32'(m_active && m_age >= 2));
        chk("redirect_pc", s_rpc, m_rpc);

        if (rst) begin
            m_active = 1'b0; m_age = 0; m_cause = 32'd0; m_epc = 32'd0; m_rpc = 32'd0;
        end else if (!m_active) begin
            if (sel_v) begin
                m_active = 1'b1; m_age = 1; m_kind = sel_kind; m_code = sel_code;
                m_cause = sel_cause; m_epc = req_pc;
                m_cmd = (sel_kind == 0) ? C_EXC : (sel_kind == 1) ? C_INT : (sel_kind == 2) ? C_MRET : C_SRET;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            case (m_kind)
                0:       m_rpc = csr_mtvec & ~32'h3;
                1:       m_rpc = (csr_mtvec & ~32'h3) + (VEC ? 32'(m_code) * 32'd4 : 32'd0);
                2:       m_rpc = csr_mepc;
                default: m_rpc = csr_sepc;
            endcase
        end else if (redirect_ready) begin
            m_active = 1'b0;
        end else begin
            m_age++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait for acceptance, drop the return/exception request, capture CMD and REDIR cycles.
    task automatic run_seq(output logic [3:0] cmd, output logic [31:0] cause, output logic [31:0] rpc);
        int k = 0;
        step();
        while (!s_ack && k < 8) begin step(); k++; end
        chk("seq_accepted", 32'(s_ack), 32'd1);
        exc_valid = 1'b0; mret_req = 1'b0; sret_req = 1'b0;
        step(); cmd = s_cmd; cause = s_cause;
        step(); rpc = s_rpc;
        step();
    endtask

    logic [3:0]  r_cmd;
    logic [31:0] r_cause, r_rpc;
    logic [31:0] got [4];
    int          ngot;
    int          cnt;

    initial begin
        m_active = 1'b0; m_age = 0; m_kind = 0; m_code = 4'd0; m_cmd = C_NONE;
        m_cause = 32'd0; m_epc = 32'd0; m_rpc = 32'd0;
        rst = 1'b1;
        irq_timer = 1'b0; irq_exti = 1'b0; irq_swi = 1'b0;
        irq_timer_en = 1'b0; irq_exti_en = 1'b0; irq_swi_en = 1'b0;
        csr_mcurrent_privilege = 2'b11; csr_mstatus_tsr = 1'b0;
        csr_mtvec = 32'd0; csr_mepc = 32'd0; csr_sepc = 32'd0;
        exc_valid = 1'b0; exc_cause = 32'd0; mret_req = 1'b0; sret_req = 1'b0;
        req_pc = 32'd0; int_allowed = 1'b0; redirect_ready = 1'b1;

        step(); step();
        chk("reset_busy", 32'(s_busy), 32'd0);
        chk("reset_cmd", 32'(s_cmd), 32'(C_NONE));
        chk("reset_rvalid", 32'(s_rv), 32'd0);
        chk("reset_rpc", s_rpc, 32'd0);
        chk("reset_cause", s_cause, 32'd0);
        chk("reset_epc", s_epc, 32'd0);
        rst = 1'b0;

        // Basic exception: 3-cycle sequence with ready held high.
        exc_valid = 1'b1; exc_cause = 32'd5; req_pc = 32'h100; csr_mtvec = 32'h8000_0003;
        step(); chk("exc_t0_ack", 32'(s_ack), 32'd1);
        exc_valid = 1'b0;
        step();
        chk("exc_t1_cmd", 32'(s_cmd), 32'(C_EXC));
        chk("exc_t1_cause", s_cause, 32'd5);
        chk("exc_t1_epc", s_epc, 32'h100);
        step();
        chk("exc_t2_rvalid", 32'(s_rv), 32'd1);
        chk("exc_t2_rpc", s_rpc, 32'h8000_0000);
        step(); chk("exc_t3_busy", 32'(s_busy), 32'd0);

        // Vectored external interrupt, latency through the synchronizer.
        irq_exti_en = 1'b1; int_allowed = 1'b1; csr_mtvec = 32'h1000; req_pc = 32'h200; irq_exti = 1'b1;
        cnt = 0;
        step();
        while (!s_ack && cnt < 10) begin step(); cnt++; end
        chk("exti_latency", 32'(cnt), 32'(SYNC));
        irq_exti_en = 1'b0; irq_exti = 1'b0;
        step();
        chk("exti_cmd", 32'(s_cmd), 32'(C_INT));
        chk("exti_cause", s_cause, 32'h8000_000B);
        chk("exti_epc", s_epc, 32'h200);
        step(); chk("exti_rpc", s_rpc, 32'h102C);
        step();

        // Exception plus all three interrupts pending together.
        int_allowed = 1'b0;
        irq_timer = 1'b1; irq_exti = 1'b1; irq_swi = 1'b1;
        irq_timer_en = 1'b1; irq_exti_en = 1'b1; irq_swi_en = 1'b1;
        for (int i = 0; i < int'(SYNC) + 1; i++) step();
        exc_valid = 1'b1; exc_cause = 32'd13; int_allowed = 1'b1;
        ngot = 0;
        for (int i = 0; i < 40 && ngot < 4; i++) begin
            step();
            if (s_cmd != C_NONE) begin
                got[ngot] = s_cause;
                ngot++;
                if (s_cmd == C_EXC) exc_valid = 1'b0;
                if (s_cmd == C_INT) begin
                    if (s_cause[3:0] == 4'd11) irq_exti_en = 1'b0;
                    if (s_cause[3:0] == 4'd3)  irq_swi_en = 1'b0;
                    if (s_cause[3:0] == 4'd7)  irq_timer_en = 1'b0;
                end
            end
        end
        chk("prio_count", 32'(ngot), 32'd4);
        if (ngot == 4) begin
            chk("prio_0_exc", got[0], 32'd13);
            chk("prio_1_exti", got[1], 32'h8000_000B);
            chk("prio_2_swi", got[2], 32'h8000_0003);
            chk("prio_3_timer", got[3], 32'h8000_0007);
        end
        irq_timer = 1'b0; irq_exti = 1'b0; irq_swi = 1'b0;
        exc_valid = 1'b0; int_allowed = 1'b0;
        step(); step();

        // Return legality.
        csr_mcurrent_privilege = 2'b01; csr_mtvec = 32'h4000; mret_req = 1'b1;
        run_seq(r_cmd, r_cause, r_rpc);
        chk("mret_illegal_cmd", 32'(r_cmd), 32'(C_EXC));
        chk("mret_illegal_cause", r_cause, 32'd2);
        chk("mret_illegal_rpc", r_rpc, 32'h4000);

        csr_mstatus_tsr = 1'b0; csr_sepc = 32'h2000; sret_req = 1'b1;
        run_seq(r_cmd, r_cause, r_rpc);
        chk("sret_cmd", 32'(r_cmd), 32'(C_SRET));
        chk("sret_rpc", r_rpc, 32'h2000);

        csr_mstatus_tsr = 1'b1; sret_req = 1'b1;
        run_seq(r_cmd, r_cause, r_rpc);
        chk("sret_tsr_cmd", 32'(r_cmd), 32'(C_EXC));
        chk("sret_tsr_cause", r_cause, 32'd2);

        csr_mcurrent_privilege = 2'b11; csr_mepc = 32'h3000; mret_req = 1'b1;
        run_seq(r_cmd, r_cause, r_rpc);
        chk("mret_cmd", 32'(r_cmd), 32'(C_MRET));
        chk("mret_rpc", r_rpc, 32'h3000);

        // Fetch backpressure, then reset while redirecting.
        redirect_ready = 1'b0; exc_valid = 1'b1; exc_cause = 32'd4;
        cnt = 0;
        step();
        while (!s_ack && cnt < 8) begin step(); cnt++; end
        exc_valid = 1'b0;
        step();
        csr_mtvec = 32'h9000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rvalid", 32'(s_rv), 32'd1);
            chk("bp_rpc", s_rpc, 32'h4000);
            chk("bp_busy", 32'(s_busy), 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_redir_rvalid", 32'(s_rv), 32'd0);
        chk("rst_redir_cmd", 32'(s_cmd), 32'(C_NONE));
        chk("rst_redir_busy", 32'(s_busy), 32'd0);
        redirect_ready = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (s_ack) begin exc_valid = 1'b0; mret_req = 1'b0; sret_req = 1'b0; end
            if (!exc_valid && !mret_req && !sret_req && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin exc_valid = 1'b1; exc_cause = $urandom; end
                    1:       mret_req = 1'b1;
                    default: sret_req = 1'b1;
                endcase
                req_pc = $urandom;
            end
            if ($urandom_range(0, 15) == 0) irq_timer = ~irq_timer;
            if ($urandom_range(0, 15) == 0) irq_exti = ~irq_exti;
            if ($urandom_range(0, 15) == 0) irq_swi = ~irq_swi;
            if ($urandom_range(0, 7) == 0) irq_timer_en = ~irq_timer_en;
            if ($urandom_range(0, 7) == 0) irq_exti_en = ~irq_exti_en;
            if ($urandom_range(0, 7) == 0) irq_swi_en = ~irq_swi_en;
            int_allowed = ($urandom_range(0, 3) != 0);
            csr_mcurrent_privilege = 2'($urandom_range(0, 3));
            csr_mstatus_tsr = 1'($urandom_range(0, 1));
            csr_mtvec = $urandom; csr_mepc = $urandom; csr_sepc = $urandom;
            redirect_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
